// File: rtl/fake_signal_checker.sv
// Receive-side checker for the injected pedestal/ramp test pattern on one packed ADC channel.
// Optional macro FAKE_CHECK_LG_EN: when defined the LG field is compared too; otherwise only HG is checked.
module fake_signal_checker #(
  parameter int unsigned PEDESTAL = 200,
  parameter int unsigned RAMP_LEN = 1847,
  parameter int unsigned LG_SHIFT = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        CLEAR,
  input  logic [23:0] ADC_IN,
  output logic        LOCKED,
  output logic        ERR_STB,
  output logic [15:0] PULSE_CNT,
  output logic [15:0] ERR_CNT,
  output logic [31:0] PERIOD,
  output logic [1:0]  dbg_state
);

  localparam int unsigned EW = $clog2(RAMP_LEN + 1);
`ifdef FAKE_CHECK_LG_EN
  localparam bit LG_EN = 1'b1;
`else
  localparam bit LG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, RAMP = 2'd2} state_t;

  state_t state, state_n;
  logic [EW-1:0] e, e_n;
  logic [31:0] per_cnt;
  logic per_valid;
  logic err, start, done;

  logic [11:0] hg, lg;
  logic [12:0] exp_hg, exp_lg;
  logic ped_ok, one_ok, ramp_ok;

  assign hg = ADC_IN[23:12];
  assign lg = ADC_IN[11:0];

  // 13-bit expected values so a ramp that overshoots 12 bits can never alias to a match.
  assign exp_hg = 13'(PEDESTAL) + 13'(e);
  assign exp_lg = 13'(PEDESTAL) + 13'(e >> LG_SHIFT);

  assign ped_ok  = ({1'b0, hg} == 13'(PEDESTAL)) &&
                   (!LG_EN || ({1'b0, lg} == 13'(PEDESTAL)));
  assign one_ok  = ({1'b0, hg} == 13'(PEDESTAL + 1)) &&
                   (!LG_EN || ({1'b0, lg} == 13'(PEDESTAL + (1 >> LG_SHIFT))));
  assign ramp_ok = ({1'b0, hg} == exp_hg) && (!LG_EN || ({1'b0, lg} == exp_lg));

  assign dbg_state = state;

  always_comb begin
    state_n = state;
    e_n     = e;
    err     = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    if (!ENABLE) begin
      state_n = SYNC;
    end else begin
      case (state)
        SYNC: if (ped_ok) state_n = IDLE;
        IDLE: begin
          if (ped_ok) begin
            state_n = IDLE;
          end else if (one_ok) begin
            state_n = RAMP;
            e_n     = EW'(2);
            start   = 1'b1;
          end else begin
            state_n = SYNC;
            err     = 1'b1;
          end
        end
        RAMP: begin
          if (!ramp_ok) begin
            state_n = SYNC;
            err     = 1'b1;
          end else if (e == EW'(RAMP_LEN)) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            e_n = e + EW'(1);
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= SYNC;
      e         <= '0;
      LOCKED    <= 1'b0;
      ERR_STB   <= 1'b0;
      PULSE_CNT <= '0;
      ERR_CNT   <= '0;
      PERIOD    <= '0;
      per_cnt   <= '0;
      per_valid <= 1'b0;
    end else begin
      state   <= state_n;
      e       <= e_n;
      LOCKED  <= (state_n != SYNC);
      ERR_STB <= err;
      if (CLEAR) begin
        PULSE_CNT <= '0;
        ERR_CNT   <= '0;
        PERIOD    <= '0;
      end else begin
        if (done && (PULSE_CNT != 16'hFFFF)) PULSE_CNT <= PULSE_CNT + 16'd1;
        if (err && (ERR_CNT != 16'hFFFF)) ERR_CNT <= ERR_CNT + 16'd1;
        if (start && per_valid) PERIOD <= per_cnt;
      end
      // Any trip through SYNC breaks the start-to-start reference.
      if (!ENABLE || err) per_valid <= 1'b0;
      else if (start) per_valid <= 1'b1;
      if (ENABLE) begin
        if (start) per_cnt <= 32'd1;
        else if (per_cnt != 32'hFFFFFFFF) per_cnt <= per_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fake_signal_checker.sv
// Directed bench for fake_signal_checker: one task per scenario, inline checks, one summary line.
module tb_fake_signal_checker;

  localparam int RLEN = 1847;
  localparam logic [11:0] PED = 12'd200;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b1;
  logic        CLEAR = 1'b0;
  logic [23:0] ADC_IN = '0;
  logic        LOCKED;
  logic        ERR_STB;
  logic [15:0] PULSE_CNT;
  logic [15:0] ERR_CNT;
  logic [31:0] PERIOD;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "watchdog expired");
  end

  fake_signal_checker dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CLEAR(CLEAR), .ADC_IN(ADC_IN),
    .LOCKED(LOCKED), .ERR_STB(ERR_STB), .PULSE_CNT(PULSE_CNT), .ERR_CNT(ERR_CNT),
    .PERIOD(PERIOD), .dbg_state(dbg_state)
  );

  function automatic logic [11:0] hg_of(input int e);
    return 12'(200 + e);
  endfunction

  function automatic logic [11:0] lg_of(input int e);
    return 12'(200 + (e >> 5));
  endfunction

  // driver tasks: inputs change at a negedge, response is sampled at the next negedge
  task automatic step(input logic [11:0] hg, input logic [11:0] lg);
    ADC_IN = {hg, lg};
    @(negedge CLK);
  endtask

  task automatic pedestal(input int n);
    for (int i = 0; i < n; i++) step(PED, PED);
  endtask

  task automatic ramp(input int from, input int to);
    for (int e = from; e <= to; e++) step(hg_of(e), lg_of(e));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ENABLE = 1'b1;
    CLEAR = 1'b0;
    ADC_IN = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({LOCKED, ERR_STB, PULSE_CNT, ERR_CNT, PERIOD} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got L=%0b S=%0b P=%0d E=%0d PER=%0d want all 0",
               LOCKED, ERR_STB, PULSE_CNT, ERR_CNT, PERIOD);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    RST = 1'b0;
    pedestal(4);
    ramp(1, RLEN);
    pedestal(2);
    n_cmp++;
    if (PULSE_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_pre_pulse: got %0d want 1", PULSE_CNT);
    end
    ramp(1, 500);
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({LOCKED, ERR_STB, PULSE_CNT, ERR_CNT, PERIOD} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got L=%0b S=%0b P=%0d E=%0d PER=%0d want all 0",
               LOCKED, ERR_STB, PULSE_CNT, ERR_CNT, PERIOD);
    end
    ramp(501, 502);
    n_cmp++;
    if ({LOCKED, ERR_STB, PULSE_CNT, ERR_CNT, PERIOD} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got L=%0b S=%0b P=%0d E=%0d PER=%0d want all 0",
               LOCKED, ERR_STB, PULSE_CNT, ERR_CNT, PERIOD);
    end
    RST = 1'b0;
    ramp(503, RLEN);
    pedestal(2);
    n_cmp++;
    if (PULSE_CNT !== 16'd0 || ERR_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_partial: got P=%0d E=%0d want 0 0", PULSE_CNT, ERR_CNT);
    end
  endtask

  task automatic test_lock();
    do_reset();
    step(PED, PED);
    n_cmp++;
    if (LOCKED !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_2nd_cycle: got %0b want 1", LOCKED);
    end
    pedestal(3);
    ramp(1, RLEN - 1);
    n_cmp++;
    if (PULSE_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL lock_before_last: got %0d want 0", PULSE_CNT);
    end
    ramp(RLEN, RLEN);
    n_cmp++;
    if (PULSE_CNT !== 16'd1 || ERR_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL lock_pulse: got P=%0d E=%0d want 1 0", PULSE_CNT, ERR_CNT);
    end
    pedestal(1);
    n_cmp++;
    if (LOCKED !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_after: got %0b want 1", LOCKED);
    end
  endtask

  task automatic test_period();
    do_reset();
    pedestal(4);
    ramp(1, RLEN);
    n_cmp++;
    if (PERIOD !== 32'd0) begin
      n_fail++;
      $display("FAIL period_first: got %0d want 0", PERIOD);
    end
    pedestal(3000 - RLEN);
    ramp(1, 1);
    n_cmp++;
    if (PERIOD !== 32'd3000) begin
      n_fail++;
      $display("FAIL period_3000: got %0d want 3000", PERIOD);
    end
    ramp(2, RLEN);
    n_cmp++;
    if (PULSE_CNT !== 16'd2) begin
      n_fail++;
      $display("FAIL period_pulses: got %0d want 2", PULSE_CNT);
    end
    CLEAR = 1'b1;
    step(PED, PED);
    CLEAR = 1'b0;
    n_cmp++;
    if (PULSE_CNT !== 16'd0 || PERIOD !== 32'd0 || LOCKED !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_counters: got P=%0d PER=%0d L=%0b want 0 0 1", PULSE_CNT, PERIOD, LOCKED);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    do_reset();
    pedestal(2);
    for (int k = 1; k <= 3; k++) exp_q.push_back(16'(k));
    for (int k = 0; k < 3; k++) begin
      ramp(1, RLEN);
      exp = exp_q.pop_front();
      n_cmp++;
      if (PULSE_CNT !== exp) begin
        n_fail++;
        $display("FAIL b2b_pulse%0d: got %0d want %0d", k, PULSE_CNT, exp);
      end
    end
    n_cmp++;
    if (PERIOD !== 32'(RLEN) || ERR_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_period: got PER=%0d E=%0d want %0d 0", PERIOD, ERR_CNT, RLEN);
    end
  endtask

  task automatic test_ramp_error();
    do_reset();
    pedestal(2);
    ramp(1, 99);
    step(12'd301, lg_of(100));
    n_cmp++;
    if (ERR_STB !== 1'b1 || ERR_CNT !== 16'd1 || LOCKED !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_err: got S=%0b E=%0d L=%0b want 1 1 0", ERR_STB, ERR_CNT, LOCKED);
    end
    ramp(101, 101);
    n_cmp++;
    if (ERR_STB !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_err_strobe: got %0b want 0", ERR_STB);
    end
    ramp(102, RLEN);
    n_cmp++;
    if (LOCKED !== 1'b0 || ERR_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL ramp_err_sync: got L=%0b E=%0d want 0 1", LOCKED, ERR_CNT);
    end
    step(PED, PED);
    n_cmp++;
    if (LOCKED !== 1'b1 || PULSE_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL ramp_err_relock: got L=%0b P=%0d want 1 0", LOCKED, PULSE_CNT);
    end
  endtask

  task automatic test_lg_only();
    logic [15:0] exp_err, exp_pulse;
`ifdef FAKE_CHECK_LG_EN
    exp_err = 16'd1;
    exp_pulse = 16'd0;
`else
    exp_err = 16'd0;
    exp_pulse = 16'd1;
`endif
    do_reset();
    pedestal(2);
    ramp(1, 63);
    step(hg_of(64), 12'd201);
    ramp(65, RLEN);
    step(PED, PED);
    n_cmp++;
    if (ERR_CNT !== exp_err || PULSE_CNT !== exp_pulse) begin
      n_fail++;
      $display("FAIL lg_only: got E=%0d P=%0d want %0d %0d", ERR_CNT, PULSE_CNT, exp_err, exp_pulse);
    end
  endtask

  task automatic test_enable();
    do_reset();
    pedestal(2);
    ramp(1, 10);
    ENABLE = 1'b0;
    ramp(11, 11);
    n_cmp++;
    if (LOCKED !== 1'b0 || ERR_STB !== 1'b0 || ERR_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL enable_off: got L=%0b S=%0b E=%0d want 0 0 0", LOCKED, ERR_STB, ERR_CNT);
    end
    ENABLE = 1'b1;
    ramp(12, 20);
    step(PED, PED);
    ramp(1, RLEN);
    n_cmp++;
    if (PERIOD !== 32'd0 || PULSE_CNT !== 16'd1 || ERR_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL enable_ref: got PER=%0d P=%0d E=%0d want 0 1 0", PERIOD, PULSE_CNT, ERR_CNT);
    end
  endtask

  task automatic test_sat_clear();
    do_reset();
    pedestal(2);
    force dut.ERR_CNT = 16'hFFFF;
    #1;
    release dut.ERR_CNT;
    step(12'd500, PED);
    n_cmp++;
    if (ERR_CNT !== 16'hFFFF || ERR_STB !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sat: got E=%h S=%0b want ffff 1", ERR_CNT, ERR_STB);
    end
    step(PED, PED);
    CLEAR = 1'b1;
    step(12'd500, PED);
    CLEAR = 1'b0;
    n_cmp++;
    if (ERR_CNT !== 16'd0 || ERR_STB !== 1'b1 || LOCKED !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_vs_err: got E=%0d S=%0b L=%0b want 0 1 0", ERR_CNT, ERR_STB, LOCKED);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_period();
    test_back_to_back();
    test_ramp_error();
    test_lg_only();
    test_enable();
    test_sat_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
